// File: rtl/sent_rx_frame_decoder.sv
// SENT receiver front end: line sync, tick measurement, frame decode and CRC request.
// Optional `SENT_RX_PAUSE_EN adds a pause-pulse state between frames.
//
// Ports:
//   clk_rx, reset_n_rx     receiver clock, async active-low reset
//   sent_rx_i              raw SENT line (asynchronous)
//   crc_check_done_i       2'b01 = CRC checker consumed the request
//   enable_crc_check_o     request code (001/010/011 for 6/4/3 nibbles), 000 idle
//   data_check_crc_o       right-justified {data nibbles, crc}
//   status_nibble_o        status nibble of the last issued frame
//   frame_error_o          one-cycle pulse on a malformed frame
//   overrun_o              one-cycle pulse when an unacked request is replaced
module sent_rx_frame_decoder #(
    parameter int CLK_PER_TICK = 4,
    parameter int DATA_NIBBLES = 6,
    parameter int TICK_CNT_W   = 10
) (
    input  logic        clk_rx,
    input  logic        reset_n_rx,
    input  logic        sent_rx_i,
    input  logic [1:0]  crc_check_done_i,
    output logic [2:0]  enable_crc_check_o,
    output logic [29:0] data_check_crc_o,
    output logic [3:0]  status_nibble_o,
    output logic        frame_error_o,
    output logic        overrun_o
);

    localparam int PW = $clog2(CLK_PER_TICK);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_PER_TICK / 2);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_PER_TICK - 1);
    localparam logic [TICK_CNT_W-1:0] T_MAX = '1;
    localparam logic [TICK_CNT_W-1:0] T_SYNC = TICK_CNT_W'(56);
    localparam logic [TICK_CNT_W-1:0] T_NMIN = TICK_CNT_W'(12);
    localparam logic [TICK_CNT_W-1:0] T_NMAX = TICK_CNT_W'(27);
    localparam logic [2:0] REQ_CODE = (DATA_NIBBLES == 6) ? 3'b001 :
                                      (DATA_NIBBLES == 4) ? 3'b010 : 3'b011;
    localparam logic [2:0] CNT_LAST = 3'(DATA_NIBBLES - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_STATUS,
        S_DATA,
        S_CRC,
`ifdef SENT_RX_PAUSE_EN
        S_EXP_SYNC,
        S_PAUSE
`else
        S_EXP_SYNC
`endif
    } state_t;

    state_t r_state, w_next;

    logic [1:0]            r_sync;
    logic                  r_last;
    logic                  r_fall;
    logic                  r_armed;
    logic [PW-1:0]         r_presc;
    logic [TICK_CNT_W-1:0] r_tick;
    logic [3:0]            r_status;
    logic [25:0]           r_frame;
    logic [2:0]            r_cnt;
    logic [2:0]            r_en;
    logic [29:0]           r_data;
    logic [3:0]            r_stat_o;
    logic                  r_err;
    logic                  r_ovr;

    logic       w_sync, w_nib, w_ack;
    logic [3:0] w_nibble;
    logic       w_err, w_issue, w_lat_st, w_store;

    assign w_sync   = (r_tick == T_SYNC);
    assign w_nib    = (r_tick >= T_NMIN) && (r_tick <= T_NMAX);
    // Low nibble arithmetic is enough: 12..27 minus 12 maps onto 0..15.
    assign w_nibble = r_tick[3:0] - 4'd12;
    assign w_ack    = (crc_check_done_i == 2'b01);

`ifdef SENT_RX_PAUSE_EN
    logic w_pause;
    assign w_pause = (r_tick >= T_NMIN) && (r_tick <= TICK_CNT_W'(768));
`endif

    // Line conditioning and interval measurement.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_sync  <= 2'b11;
            r_last  <= 1'b1;
            r_fall  <= 1'b0;
            r_armed <= 1'b0;
            r_presc <= '0;
            r_tick  <= '0;
        end else begin
            r_sync <= {r_sync[0], sent_rx_i};
            r_last <= r_sync[1];
            r_fall <= r_last & ~r_sync[1];
            if (r_fall) begin
                r_armed <= 1'b1;
                // Half-tick preload rounds the interval to the nearest tick.
                r_presc <= P_HALF;
                r_tick  <= '0;
            end else if (r_presc == P_LAST) begin
                r_presc <= '0;
                if (r_tick != T_MAX) r_tick <= r_tick + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) r_state <= S_HUNT;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_err    = 1'b0;
        w_issue  = 1'b0;
        w_lat_st = 1'b0;
        w_store  = 1'b0;
        if (r_fall && r_armed) begin
            unique case (r_state)
                S_HUNT: begin
                    if (w_sync) w_next = S_STATUS;
                end
                S_STATUS: begin
                    if (w_nib) begin
                        w_lat_st = 1'b1;
                        w_next   = S_DATA;
                    end else if (!w_sync) begin
                        w_err  = 1'b1;
                        w_next = S_HUNT;
                    end
                end
                S_DATA, S_CRC: begin
                    if (w_nib && r_state == S_DATA) begin
                        w_store = 1'b1;
                        if (r_cnt == CNT_LAST) w_next = S_CRC;
                    end else if (w_nib) begin
                        w_issue = 1'b1;
                        w_next  = S_EXP_SYNC;
                    end else begin
                        w_err  = 1'b1;
                        w_next = w_sync ? S_STATUS : S_HUNT;
                    end
                end
                S_EXP_SYNC: begin
                    if (w_sync) begin
                        w_next = S_STATUS;
`ifdef SENT_RX_PAUSE_EN
                    end else if (w_pause) begin
                        w_next = S_PAUSE;
`endif
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_HUNT;
                    end
                end
`ifdef SENT_RX_PAUSE_EN
                S_PAUSE: begin
                    if (w_sync) begin
                        w_next = S_STATUS;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_HUNT;
                    end
                end
`endif
                default: w_next = S_HUNT;
            endcase
        end else if (!r_fall && r_tick == T_MAX && r_state != S_HUNT) begin
            // Line stuck mid-frame: abandon without waiting for an edge.
            w_err  = 1'b1;
            w_next = S_HUNT;
        end
    end

    // Frame assembly and CRC request handshake.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_status <= '0;
            r_frame  <= '0;
            r_cnt    <= '0;
            r_en     <= '0;
            r_data   <= '0;
            r_stat_o <= '0;
            r_err    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_err <= w_err;
            r_ovr <= w_issue && (r_en != 3'b000) && !w_ack;
            if (w_lat_st) begin
                r_status <= w_nibble;
                r_frame  <= '0;
                r_cnt    <= '0;
            end
            if (w_store) begin
                r_frame <= {r_frame[21:0], w_nibble};
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_issue) begin
                r_en     <= REQ_CODE;
                r_data   <= {r_frame, w_nibble};
                r_stat_o <= r_status;
            end else if (w_ack) begin
                r_en <= 3'b000;
            end
        end
    end

    assign enable_crc_check_o = r_en;
    assign data_check_crc_o   = r_data;
    assign status_nibble_o    = r_stat_o;
    assign frame_error_o      = r_err;
    assign overrun_o          = r_ovr;

endmodule

// File: tb/tb_sent_rx_frame_decoder.sv
// Bench for sent_rx_frame_decoder: interval-level protocol model plus literals.
// A 4-nibble instance is exercised with directed literal checks only.
module tb_sent_rx_frame_decoder;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line6 = 1'b1;
    logic        line4 = 1'b1;
    logic [1:0]  done6 = 2'b00;
    logic [1:0]  done4 = 2'b00;
    logic [2:0]  en6, en4;
    logic [29:0] data6, data4;
    logic [3:0]  st6, st4;
    logic        err6, err4, ovr6, ovr4;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sent_rx_frame_decoder #(.CLK_PER_TICK(C), .DATA_NIBBLES(6), .TICK_CNT_W(10)) dut6 (
        .clk_rx(clk), .reset_n_rx(rst_n), .sent_rx_i(line6),
        .crc_check_done_i(done6), .enable_crc_check_o(en6),
        .data_check_crc_o(data6), .status_nibble_o(st6),
        .frame_error_o(err6), .overrun_o(ovr6)
    );

    sent_rx_frame_decoder #(.CLK_PER_TICK(C), .DATA_NIBBLES(4), .TICK_CNT_W(10)) dut4 (
        .clk_rx(clk), .reset_n_rx(rst_n), .sent_rx_i(line4),
        .crc_check_done_i(done4), .enable_crc_check_o(en4),
        .data_check_crc_o(data4), .status_nibble_o(st4),
        .frame_error_o(err4), .overrun_o(ovr4)
    );

    // ---------------- model (6-nibble instance) ----------------
    typedef struct {
        int          k;   // 0 error, 1 overrun, 2 issue
        logic [29:0] d;
        logic [3:0]  s;
    } ev_t;

    ev_t q[$];
    int  m_last = -1;     // interval in flight; -1 = next edge only arms
    int  ms = 0;          // 0 hunt 1 status 2 data 3 crc 4 exp_sync 5 pause
    int  mcnt = 0;
    int  mfr = 0;
    int  mst = 0;
    bit  pend = 0;

    function automatic void m_push(int k, int d, int s);
        ev_t e;
        e.k = k;
        e.d = 30'(d);
        e.s = 4'(s);
        q.push_back(e);
    endfunction

    function automatic void m_edge(int t);
        bit sy = (t == 56);
        bit nb = (t >= 12 && t <= 27);
        int n = t - 12;
        if (t < 0) return;
        case (ms)
            0: if (sy) ms = 1;
            1: begin
                if (nb) begin
                    mst = n; mfr = 0; mcnt = 0; ms = 2;
                end else if (!sy) begin
                    m_push(0, 0, 0); ms = 0;
                end
            end
            2, 3: begin
                if (nb && ms == 2) begin
                    mfr = mfr * 16 + n;
                    mcnt++;
                    if (mcnt == 6) ms = 3;
                end else if (nb) begin
                    if (pend) m_push(1, 0, 0);
                    m_push(2, mfr * 16 + n, mst);
                    pend = 1;
                    ms = 4;
                end else begin
                    m_push(0, 0, 0);
                    ms = sy ? 1 : 0;
                end
            end
            4: begin
                if (sy) ms = 1;
`ifdef SENT_RX_PAUSE_EN
                else if (t >= 12 && t <= 768) ms = 5;
`endif
                else begin m_push(0, 0, 0); ms = 0; end
            end
            default: begin
                if (sy) ms = 1;
                else begin m_push(0, 0, 0); ms = 0; end
            end
        endcase
    endfunction

    // ---------------- checking ----------------
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void expect_ev(int k, logic [29:0] d, logic [3:0] s,
                                      logic [2:0] en, string nm);
        ev_t e;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event d=%0h s=%0h, none expected",
                     nm, d, s);
            return;
        end
        e = q.pop_front();
        if (e.k != k) begin
            n_fail++;
            $display("FAIL %s: got event kind %0d expected kind %0d", nm, k, e.k);
        end else if (k == 2 && (e.d !== d || e.s !== s || en !== 3'b001)) begin
            n_fail++;
            $display("FAIL %s: got d=%0h s=%0h en=%0b expected d=%0h s=%0h en=001",
                     nm, d, s, en, e.d, e.s);
        end
    endfunction

    logic [2:0]  p_en;
    logic [29:0] p_d;
    logic [3:0]  p_s;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_en = '0; p_d = '0; p_s = '0;
        end else begin
            if (err6) expect_ev(0, '0, '0, '0, "frame_error");
            if (ovr6) expect_ev(1, '0, '0, '0, "overrun");
            if (en6 != 3'b000 && (p_en == 3'b000 || data6 != p_d || st6 != p_s))
                expect_ev(2, data6, st6, en6, "issue");
            p_en = en6; p_d = data6; p_s = st6;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fall(input bit four, input int ticks);
        if (four) line4 = 1'b0;
        else begin
            line6 = 1'b0;
            m_edge(m_last);
            m_last = ticks;
        end
        cyc(5 * C);
        if (four) line4 = 1'b1;
        else line6 = 1'b1;
    endtask

    task automatic rest(input int ticks, input int adj);
        cyc(ticks * C + adj - 5 * C);
    endtask

    task automatic pulse(input bit four, input int ticks, input int jit);
        fall(four, ticks);
        rest(ticks, jit);
    endtask

    task automatic frame(input bit four, input int st, input int d,
                         input int nn, input int crc, input bit jit);
        pulse(four, 12 + st, jit ? 1 : 0);
        for (int i = 0; i < nn; i++)
            pulse(four, 12 + ((d >> (4 * (nn - 1 - i))) & 15),
                  jit ? ((i % 2) ? 1 : -1) : 0);
        pulse(four, 12 + crc, jit ? -1 : 0);
    endtask

    task automatic ack6();
        done6 = 2'b01;
        pend = 0;
        cyc(1);
        done6 = 2'b00;
    endtask

    initial begin
        cyc(2);
        chk("rst_en", 32'(en6), 32'h0);
        chk("rst_data", 32'(data6), 32'h0);
        chk("rst_status", 32'(st6), 32'h0);
        chk("rst_err", 32'(err6), 32'h0);
        chk("rst_ovr", 32'(ovr6), 32'h0);
        cyc(3);
        rst_n = 1'b1;
        cyc(4);

        // 4-nibble instance
        pulse(1, 56, 0);
        frame(1, 0, 'hF0F0, 4, 3, 0);
        fall(1, 56);
        chk("n4_en", 32'(en4), 32'h2);
        chk("n4_data", 32'(data4), 32'h000F0F03);
        chk("n4_status", 32'(st4), 32'h0);
        rest(56, 0);

        // basic frame and handshake timing
        pulse(0, 56, 0);
        frame(0, 5, 'h123456, 6, 'hA, 0);
        fall(0, 56);
        chk("f1_en", 32'(en6), 32'h1);
        chk("f1_data", 32'(data6), 32'h0123456A);
        chk("f1_status", 32'(st6), 32'h5);
        cyc(2);
        done6 = 2'b01;
        pend = 0;
        chk("f1_en_at_done", 32'(en6), 32'h1);
        cyc(1);
        done6 = 2'b00;
        chk("f1_en_cleared", 32'(en6), 32'h0);
        chk("f1_data_held", 32'(data6), 32'h0123456A);
        rest(56, -3);

        // 28-tick data pulse, then recovery after the next sync
        pulse(0, 15, 0);
        pulse(0, 19, 0);
        pulse(0, 20, 0);
        pulse(0, 28, 0);
        pulse(0, 56, 0);
        frame(0, 9, 'h0F1E2D, 6, 4, 0);
        fall(0, 56);
        chk("f2_data", 32'(data6), 32'h00F1E2D4);
        ack6();
        rest(56, -1);

        // bad status, hunt ignores 55/57, jittered frame
        pulse(0, 30, 0);
        pulse(0, 55, 0);
        pulse(0, 57, 0);
        pulse(0, 56, 0);
        frame(0, 'hC, 'h314159, 6, 2, 1);
        fall(0, 56);
        chk("f3_data", 32'(data6), 32'h03141592);
        chk("f3_status", 32'(st6), 32'hC);
        ack6();
        rest(56, -1);

        // 100-tick pause after the CRC
        frame(0, 6, 'hABCDEF, 6, 7, 0);
        fall(0, 100);
        chk("f4_data", 32'(data6), 32'h0ABCDEF7);
        ack6();
        rest(100, -1);
        pulse(0, 56, 0);
        frame(0, 1, 'h222222, 6, 2, 0);
        fall(0, 56);
        chk("f5_data", 32'(data6), 32'h02222222);
        ack6();
        rest(56, -1);

        // two frames without acknowledge
        frame(0, 7, 'h111111, 6, 1, 0);
        fall(0, 56);
        rest(56, 0);
        frame(0, 8, 'h987654, 6, 3, 0);
        fall(0, 56);
        chk("ovr_data", 32'(data6), 32'h09876543);
        chk("ovr_status", 32'(st6), 32'h8);
        ack6();
        rest(56, -1);

        // reset in the middle of the data nibbles
        pulse(0, 16, 0);
        pulse(0, 13, 0);
        pulse(0, 14, 0);
        chk("events_drained", 32'(q.size()), 32'h0);
        rst_n = 1'b0;
        m_last = -1;
        ms = 0;
        pend = 0;
        cyc(2);
        chk("mid_rst_en", 32'(en6), 32'h0);
        chk("mid_rst_data", 32'(data6), 32'h0);
        chk("mid_rst_status", 32'(st6), 32'h0);
        chk("mid_rst_err_ovr", 32'({err6, ovr6}), 32'h0);
        rst_n = 1'b1;
        cyc(40);
        chk("final_events", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
